// File: rtl/key_scheduler_if.sv
// Key-write handshake bundle for key_scheduler.
// Master issues slot writes; slave accepts them with cfg_ready.
interface key_scheduler_if #(
  parameter int KEY_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_idx;
  logic [KEY_W-1:0] cfg_key;

  modport master (
    output cfg_valid,
    output cfg_idx,
    output cfg_key,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_idx,
    input  cfg_key,
    output cfg_ready
  );
endinterface

// File: rtl/key_scheduler.sv
// Key slot store and windowed key sequencer
// feeding the key bus of a locked FSM.
module key_scheduler #(
  parameter int KEY_W    = 16,
  parameter int NUM_KEYS = 5,
  parameter int WIN_LEN  = 10
) (
  input  logic             clk,
  input  logic             rst,
  key_scheduler_if.slave   cfg,
  input  logic             arm,
  input  logic             stop,
  output logic [KEY_W-1:0] key_out,
  output logic [2:0]       win_idx,
  output logic [6:0]       cnt,
  output logic             running,
  output logic             all_loaded,
  output logic             err
);

  localparam logic [6:0] LAST_CNT = 7'(NUM_KEYS * WIN_LEN - 1);
  localparam logic [6:0] LAST_SUB = 7'(WIN_LEN - 1);
  localparam logic [3:0] NK       = 4'(NUM_KEYS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [KEY_W-1:0]    r_slot [NUM_KEYS];
  logic [NUM_KEYS-1:0] r_loaded;
  logic [KEY_W-1:0]    r_key;
  logic [6:0]          r_cnt;
  logic [6:0]          r_sub;
  logic [2:0]          r_win;
  logic                r_err;

  logic                w_idle;
  logic                w_wr;
  logic                w_idx_ok;
  logic                w_all;
  logic                w_go;
  logic                w_arm_err;
  logic [6:0]          w_cnt_n;
  logic [6:0]          w_sub_n;
  logic [2:0]          w_win_n;
  logic [KEY_W-1:0]    w_slot0;

  assign w_idle    = (r_state == IDLE);
  assign w_wr      = w_idle && cfg.cfg_valid;
  assign w_idx_ok  = ({1'b0, cfg.cfg_idx} < NK);
  assign w_all     = &r_loaded;
  // arm is judged on the mask from before any same-cycle write
  assign w_go      = w_idle && arm && !stop && w_all;
  assign w_arm_err = w_idle && arm && !stop && !w_all;
  assign w_slot0   = (w_wr && cfg.cfg_idx == 3'd0)
                   ? cfg.cfg_key : r_slot[0];

  // sub-window counter keeps win_idx free of a divider
  always_comb begin
    w_cnt_n = r_cnt + 7'd1;
    w_sub_n = r_sub + 7'd1;
    w_win_n = r_win;
    if (r_cnt == LAST_CNT) begin
      w_cnt_n = '0;
      w_sub_n = '0;
      w_win_n = '0;
    end else if (r_sub == LAST_SUB) begin
      w_sub_n = '0;
      w_win_n = r_win + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (r_state == IDLE): if (w_go) w_next = RUN;
      (r_state == RUN):  if (stop) w_next = HOLD;
      (r_state == HOLD): begin
        if (stop)     w_next = IDLE;
        else if (arm) w_next = RUN;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) r_slot[i] <= '0;
      r_loaded <= '0;
      r_err    <= 1'b0;
      r_key    <= '0;
      r_cnt    <= '0;
      r_sub    <= '0;
      r_win    <= '0;
    end else begin
      if (w_wr) begin
        if (w_idx_ok) begin
          r_slot[cfg.cfg_idx]   <= cfg.cfg_key;
          r_loaded[cfg.cfg_idx] <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (w_arm_err) r_err <= 1'b1;
      if (w_go) begin
        r_cnt <= '0;
        r_sub <= '0;
        r_win <= '0;
        r_key <= w_slot0;
      end else if (r_state == RUN) begin
        r_cnt <= w_cnt_n;
        r_sub <= w_sub_n;
        r_win <= w_win_n;
        r_key <= r_slot[w_win_n];
      end else if (r_state == HOLD && stop) begin
        r_cnt <= '0;
        r_sub <= '0;
        r_win <= '0;
        r_key <= '0;
      end
    end
  end

  assign cfg.cfg_ready = w_idle;
  assign key_out       = r_key;
  assign cnt           = r_cnt;
  assign win_idx       = r_win;
  assign running       = (r_state == RUN);
  assign all_loaded    = w_all;
  assign err           = r_err;

endmodule

// File: tb/tb_key_scheduler.sv
// Scoreboard bench for key_scheduler: driver queues expected
// snapshots, a negedge monitor pops and compares them.
module tb_key_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        stop;
  logic [15:0] key_out;
  logic [2:0]  win_idx;
  logic [6:0]  cnt;
  logic        running;
  logic        all_loaded;
  logic        err;

  key_scheduler_if #(.KEY_W(16)) cfg_if ();

  key_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .cfg        (cfg_if),
    .arm        (arm),
    .stop       (stop),
    .key_out    (key_out),
    .win_idx    (win_idx),
    .cnt        (cnt),
    .running    (running),
    .all_loaded (all_loaded),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          cyc;
    logic [15:0] key;
    logic [6:0]  cnt;
    logic [2:0]  win;
    logic        run;
    logic        al;
    logic        err;
    logic        rdy;
  } exp_t;

  exp_t  q  [$];
  string nq [$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [15:0] K [5];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t  e;
      string nm;
      e  = q.pop_front();
      nm = nq.pop_front();
      n_cmp++;
      if (key_out !== e.key || cnt !== e.cnt ||
          win_idx !== e.win || running !== e.run ||
          all_loaded !== e.al || err !== e.err ||
          cfg_if.cfg_ready !== e.rdy) begin
        n_bad++;
        $display("FAIL %s: got key=%h cnt=%0d win=%0d run=%b al=%b err=%b rdy=%b want key=%h cnt=%0d win=%0d run=%b al=%b err=%b rdy=%b",
                 nm, key_out, cnt, win_idx, running, all_loaded,
                 err, cfg_if.cfg_ready, e.key, e.cnt, e.win, e.run,
                 e.al, e.err, e.rdy);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_now(input string nm, input logic [15:0] k,
                            input int c, input int w,
                            input logic r, input logic a,
                            input logic e, input logic y);
    exp_t x;
    x.cyc = cyc;
    x.key = k;
    x.cnt = 7'(c);
    x.win = 3'(w);
    x.run = r;
    x.al  = a;
    x.err = e;
    x.rdy = y;
    q.push_back(x);
    nq.push_back(nm);
  endtask

  task automatic wr(input int idx, input logic [15:0] k);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_idx   = 3'(idx);
    cfg_if.cfg_key   = k;
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    K[0] = 16'd25125;
    K[1] = 16'd58314;
    K[2] = 16'd29054;
    K[3] = 16'd18173;
    K[4] = 16'd1403;
    rst = 1'b1;
    arm = 1'b0;
    stop = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_idx   = '0;
    cfg_if.cfg_key   = '0;
    tick(2);
    rst = 1'b0;
    expect_now("reset", 0, 0, 0, 0, 0, 0, 1);

    // full load and one complete period
    for (int i = 0; i < 5; i++) wr(i, K[i]);
    expect_now("loaded", 0, 0, 0, 0, 1, 0, 1);
    pulse_arm();
    expect_now("arm_run", K[0], 0, 0, 1, 1, 0, 0);
    for (int n = 0; n < 50; n++) begin
      expect_now("period", K[n / 10], n, n / 10, 1, 1, 0, 0);
      tick();
    end
    expect_now("wrap", K[0], 0, 0, 1, 1, 0, 0);

    // hold and resume
    tick(23);
    expect_now("cnt23", K[2], 23, 2, 1, 1, 0, 0);
    pulse_stop();
    expect_now("hold", K[2], 24, 2, 0, 1, 0, 0);
    tick(3);
    expect_now("hold_frz", K[2], 24, 2, 0, 1, 0, 0);
    pulse_arm();
    expect_now("resume", K[2], 24, 2, 1, 1, 0, 0);
    tick();
    expect_now("resume25", K[2], 25, 2, 1, 1, 0, 0);
    pulse_stop();
    expect_now("hold2", K[2], 26, 2, 0, 1, 0, 0);
    pulse_stop();
    expect_now("to_idle", 0, 0, 0, 0, 1, 0, 1);

    // write attempt while running is ignored
    pulse_arm();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_idx   = 3'd0;
    cfg_if.cfg_key   = 16'hFFFF;
    #1;
    expect_now("run_nordy", K[0], 0, 0, 1, 1, 0, 0);
    tick(2);
    cfg_if.cfg_valid = 1'b0;
    pulse_stop();
    pulse_stop();
    pulse_arm();
    expect_now("run_nowr", K[0], 0, 0, 1, 1, 0, 0);

    // arm and stop together: stop wins
    arm = 1'b1;
    stop = 1'b1;
    tick();
    expect_now("as_run", K[0], 1, 0, 0, 1, 0, 0);
    tick();
    arm = 1'b0;
    stop = 1'b0;
    expect_now("as_hold", 0, 0, 0, 0, 1, 0, 1);

    // reset mid-run overrides arm and writes
    pulse_arm();
    tick(37);
    expect_now("cnt37", K[3], 37, 3, 1, 1, 0, 0);
    rst = 1'b1;
    arm = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_idx   = 3'd0;
    tick();
    rst = 1'b0;
    arm = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    expect_now("rst_run", 0, 0, 0, 0, 0, 0, 1);
    pulse_arm();
    expect_now("arm_empty", 0, 0, 0, 0, 0, 1, 1);

    // partial load
    do_reset();
    for (int i = 0; i < 4; i++) wr(i, K[i]);
    pulse_arm();
    expect_now("arm_part", 0, 0, 0, 0, 0, 1, 1);

    // last write with arm in same cycle uses old mask
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_idx   = 3'd4;
    cfg_if.cfg_key   = K[4];
    arm = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0;
    arm = 1'b0;
    expect_now("arm_wr", 0, 0, 0, 0, 1, 1, 1);
    pulse_arm();
    expect_now("arm_ok", K[0], 0, 0, 1, 1, 1, 0);

    // out-of-range write
    do_reset();
    for (int i = 0; i < 5; i++) wr(i, K[i]);
    wr(6, 16'hBEEF);
    expect_now("bad_idx", 0, 0, 0, 0, 1, 1, 1);
    pulse_arm();
    for (int w = 0; w < 5; w++) begin
      expect_now("slots", K[w], w * 10, w, 1, 1, 1, 0);
      tick(10);
    end

    // rewrite loaded slot
    pulse_stop();
    pulse_stop();
    wr(0, 16'h1234);
    expect_now("rewrite", 0, 0, 0, 0, 1, 1, 1);
    pulse_arm();
    expect_now("new_key", 16'h1234, 0, 0, 1, 1, 1, 0);

    tick(2);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/key_scheduler.md
KEY_SCHEDULER -- requirements
Module: key_scheduler

Interface
REQ-001 Parameter KEY_W, default 16, width of one key word and of the key bus driven to the locked FSM.
REQ-002 Parameter NUM_KEYS, default 5, number of key slots and key windows per period.
REQ-003 Parameter WIN_LEN, default 10, cycles per key window; period is NUM_KEYS*WIN_LEN (default 50).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cfg_valid  in  1  key-write request.
REQ-007 cfg_ready  out  1  key-write accept; a write occurs on a cycle with cfg_valid=1 and cfg_ready=1.
REQ-008 cfg_idx  in  3  target slot for the key write.
REQ-009 cfg_key  in  KEY_W  key value for the write.
REQ-010 arm  in  1  single-cycle request to start key sequencing.
REQ-011 stop  in  1  single-cycle request to end sequencing.
REQ-012 key_out  out  KEY_W  key bus to the locked FSM keyinput0..keyinput15; bit i drives keyinput i.
REQ-013 win_idx  out  3  current window number, 0..NUM_KEYS-1.
REQ-014 cnt  out  7  period counter, 0..NUM_KEYS*WIN_LEN-1.
REQ-015 running  out  1  high in state RUN.
REQ-016 all_loaded  out  1  high when every slot has been written since reset.
REQ-017 err  out  1  sticky error flag.

Function
REQ-018 Three states SHALL exist: IDLE, RUN, and HOLD.
REQ-019 IDLE: cfg_ready=1; each accepted write stores cfg_key into slot cfg_idx and sets loaded[cfg_idx].
REQ-020 A write with cfg_idx>=NUM_KEYS SHALL be accepted, store nothing, and set err.
REQ-021 A rewrite of a slot that is already loaded SHALL overwrite the slot, and the slot SHALL stay loaded.
REQ-022 IDLE with arm=1 and all_loaded=1 SHALL move to RUN on the next edge, with cnt=0 and win_idx=0.
REQ-023 IDLE with arm=1 and all_loaded=0 SHALL stay in IDLE and set err.
REQ-024 When arm and an accepted write occur in the same cycle, the write takes effect and arm SHALL be evaluated against the loaded mask from before that write.
REQ-025 RUN: cfg_ready=0; cnt increments by 1 per cycle and wraps from NUM_KEYS*WIN_LEN-1 to 0.
REQ-026 win_idx = cnt / WIN_LEN (integer division).
REQ-027 win_idx SHALL be registered together with cnt, with no combinational divider on the output path.
REQ-028 RUN: key_out = slot[win_idx], registered, so it changes only on the rising edge where cnt crosses a window boundary.
REQ-029 key_out is stable at the following falling edge, where the locked FSM samples it.
REQ-030 RUN with cfg_valid=1: no write, cfg_ready=0, err is unaffected.
REQ-031 RUN with stop=1 SHALL move to HOLD on the next edge.
REQ-032 HOLD: key_out, cnt and win_idx are frozen; cfg_ready=0.
REQ-033 HOLD with arm=1 SHALL resume RUN from the frozen cnt.
REQ-034 HOLD with stop=1 SHALL move to IDLE, with key_out=0, cnt=0 and win_idx=0.
REQ-035 If arm and stop are both 1 in one cycle, stop SHALL take priority.
REQ-036 Outside RUN and HOLD, key_out SHALL be 0.
REQ-037 err SHALL clear only on rst.

Reset
REQ-038 A synchronous rst, including one mid-RUN, SHALL force the following on the next edge: state IDLE, all slots 0, loaded mask 0, key_out 0, cnt 0, win_idx 0, running 0, all_loaded 0, err 0, cfg_ready 1.
REQ-039 rst SHALL override cfg_valid, arm and stop in the same cycle.

Verification
REQ-040 Load slots 0..4 = 25125, 58314, 29054, 18173, 1403, then arm -> running=1; key_out=25125 for cnt 0..9, 58314 for 10..19, 29054 for 20..29, 18173 for 30..39, 1403 for 40..49; cnt=0 and key_out=25125 again on the next cycle.
REQ-041 Load slots 0..3 only, then arm -> stays IDLE, err=1, key_out=0.
REQ-042 Write with cfg_idx=6 -> err=1, all_loaded unchanged, no slot modified.
REQ-043 In RUN at cnt=23, pulse stop -> HOLD, with cnt=24 and key_out=29054 held; arm -> RUN resumes, cnt=25; stop, stop -> IDLE, key_out=0.
REQ-044 Assert rst at cnt=37 in RUN -> next cycle IDLE, key_out=0, all_loaded=0; a following arm -> err=1.
REQ-045 In RUN, drive cfg_valid=1 with cfg_idx=0 and cfg_key=0xFFFF -> cfg_ready=0; after stop, stop, arm, key_out=25125 in window 0.
